fc_weight_loader: RTL and testbench

//  Write-side feeder for fc_weight_buf: accepts a packed weight byte stream from the FC DMA over a

---
 rtl/fc_weight_loader_pkg.sv | 18 +
 rtl/fc_weight_loader_if.sv | 16 +
 rtl/fc_weight_loader.sv | 131 +++++++++++++
 tb/tb_fc_weight_loader.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_weight_loader_pkg.sv
// Shared constants, weight type and loader state encoding for the FC weight buffer path.
// Package name fc_pkg is shared by the FC datapath blocks.
package fc_pkg;

  localparam int FC_NUM_LANE   = 128;
  localparam int FC_DEPTH      = 128;
  localparam int FC_ADDR_W     = $clog2(FC_DEPTH);
  localparam int FC_BEAT_BYTES = 4;

  typedef logic signed [7:0] fc_weight_t;

  typedef enum logic [1:0] {
    WL_IDLE,
    WL_LOAD,
    WL_PAD
  } fc_wload_state_e;

endpackage

// File: rtl/fc_weight_loader_if.sv
// Valid/ready byte stream carrying packed weights from the FC DMA into fc_weight_loader.
// Byte k of a beat sits in data[8k+7:8k].
interface fc_weight_loader_if
  import fc_pkg::*;
#(
  parameter int BEAT_BYTES = FC_BEAT_BYTES
);

  logic                    valid;
  logic                    ready;
  logic [8*BEAT_BYTES-1:0] data;

  modport master (output valid, output data, input  ready);
  modport slave  (input  valid, input  data, output ready);

endinterface

// File: rtl/fc_weight_loader.sv
// Unpacks the DMA weight stream into per-lane fc_weight_buf writes, row by row, up to a row count.
// Optional build macro FC_WLOAD_ZERO_PAD_EN zero-fills the rows above the programmed count.
module fc_weight_loader
  import fc_pkg::*;
#(
  parameter int NUM_LANE   = FC_NUM_LANE,
  parameter int DEPTH      = FC_DEPTH,
  parameter int BEAT_BYTES = FC_BEAT_BYTES,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start_i,
  input  logic [ADDR_W:0]                  num_rows_i,
  fc_weight_loader_if.slave                s,
  output logic                             busy_o,
  output logic                             done_o,
  output logic [NUM_LANE-1:0]              wren_o,
  output logic [NUM_LANE-1:0][ADDR_W-1:0]  wrptr_o,
  output fc_weight_t [NUM_LANE-1:0]        weight_o
);

  localparam int LANE_W = $clog2(NUM_LANE);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANE - BEAT_BYTES);
  localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W+1)'(DEPTH);

  fc_wload_state_e   state, state_next;
  logic [ADDR_W-1:0] row_cnt, last_row, wr_row;
  logic [LANE_W-1:0] lane_cnt;
  logic [ADDR_W:0]   rows_eff;
  logic              load_start, accept, row_end, last_beat, pad_write, done_next;

  assign rows_eff  = (num_rows_i > DEPTH_W) ? DEPTH_W : num_rows_i;
  assign s.ready   = (state == WL_LOAD);
  assign busy_o    = (state != WL_IDLE);
  assign accept    = s.valid & s.ready;
  assign row_end   = (lane_cnt == LAST_LANE);
  assign last_beat = accept & row_end & (row_cnt == last_row);
  assign wrptr_o   = {NUM_LANE{wr_row}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WL_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_start = 1'b0;
    pad_write  = 1'b0;
    done_next  = 1'b0;
    case (state)
      WL_IDLE: begin
        if (start_i) begin
          load_start = 1'b1;
          if (rows_eff == '0) begin
`ifdef FC_WLOAD_ZERO_PAD_EN
            state_next = WL_PAD;
`else
            done_next = 1'b1;
`endif
          end else begin
            state_next = WL_LOAD;
          end
        end
      end
      WL_LOAD: begin
        if (last_beat) begin
`ifdef FC_WLOAD_ZERO_PAD_EN
          if (last_row == LAST_ROW) begin
            done_next  = 1'b1;
            state_next = WL_IDLE;
          end else begin
            state_next = WL_PAD;
          end
`else
          done_next  = 1'b1;
          state_next = WL_IDLE;
`endif
        end
      end
`ifdef FC_WLOAD_ZERO_PAD_EN
      WL_PAD: begin
        pad_write = 1'b1;
        if (row_cnt == LAST_ROW) begin
          done_next  = 1'b1;
          state_next = WL_IDLE;
        end
      end
`endif
      default: state_next = WL_IDLE;
    endcase
  end

  // Writes land one cycle after the beat; row_cnt saturates at the last row so wrptr stays in range.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_cnt  <= '0;
      lane_cnt <= '0;
      last_row <= '0;
      wr_row   <= '0;
      wren_o   <= '0;
      weight_o <= '0;
      done_o   <= 1'b0;
    end else begin
      wren_o <= '0;
      done_o <= done_next;
      if (load_start) begin
        row_cnt  <= '0;
        lane_cnt <= '0;
        last_row <= ADDR_W'(rows_eff - 1'b1);
      end
      if (accept) begin
        for (int k = 0; k < BEAT_BYTES; k++) begin
          wren_o[lane_cnt + LANE_W'(k)]   <= 1'b1;
          weight_o[lane_cnt + LANE_W'(k)] <= s.data[8*k +: 8];
        end
        wr_row   <= row_cnt;
        lane_cnt <= row_end ? '0 : lane_cnt + LANE_W'(BEAT_BYTES);
        if (row_end && row_cnt != LAST_ROW) row_cnt <= row_cnt + 1'b1;
      end
      if (pad_write) begin
        wren_o   <= '1;
        weight_o <= '0;
        wr_row   <= row_cnt;
        if (row_cnt != LAST_ROW) row_cnt <= row_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fc_weight_loader.sv
// Scoreboard bench for fc_weight_loader: random stream in, expected writes queued, monitor compares.
// Also builds with FC_WLOAD_ZERO_PAD_EN to cover the zero-pad variant.
module tb_fc_weight_loader;
  import fc_pkg::*;

  localparam int NL  = FC_NUM_LANE;
  localparam int DP  = FC_DEPTH;
  localparam int BB  = FC_BEAT_BYTES;
  localparam int AW  = FC_ADDR_W;
  localparam int BPR = NL / BB;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     start_i = 1'b0;
  logic [AW:0]              num_rows_i = '0;
  logic                     busy, done;
  logic [NL-1:0]            wren;
  logic [NL-1:0][AW-1:0]    wrptr;
  fc_weight_t [NL-1:0]      weight;

  fc_weight_loader_if #(.BEAT_BYTES(BB)) s_if ();

  fc_weight_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .num_rows_i (num_rows_i),
    .s          (s_if),
    .busy_o     (busy),
    .done_o     (done),
    .wren_o     (wren),
    .wrptr_o    (wrptr),
    .weight_o   (weight)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               row;
    logic [NL-1:0]    mask;
    logic [NL*8-1:0]  bytes;
    logic             done;
  } exp_t;

  exp_t         exp_q[$];
  byte unsigned model_img[DP][NL];
  byte unsigned dut_img[DP][NL];
  int           checks = 0;
  int           errors = 0;
  int           done_cnt = 0;
  bit           prev_done = 1'b0;

  task automatic check_output(input string name, input logic [NL-1:0] actual, input logic [NL-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic check_reset_outputs();
    check_output("rst_wren", wren, '0);
    check_output("rst_done", NL'(done), '0);
    check_output("rst_busy", NL'(busy), '0);
    check_output("rst_ready", NL'(s_if.ready), '0);
    check_output("rst_wrptr_nonzero", NL'(wrptr != '0), '0);
    check_output("rst_weight_nonzero", NL'(weight != '0), '0);
  endtask

  // Rows from 'first' up to the top are expected to be zero-filled, done on the last one.
  task automatic push_pad(input int first);
    exp_t e;
    for (int r = first; r < DP; r++) begin
      e.row = r; e.mask = '1; e.bytes = '0; e.done = (r == DP-1);
      exp_q.push_back(e);
      for (int j = 0; j < NL; j++) model_img[r][j] = 8'h00;
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    int   bad;
    if (rst) begin
      prev_done = 1'b0;
    end else begin
      if (wren != '0) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_write", wren, '0);
        end else begin
          e = exp_q.pop_front();
          check_output("wren_mask", wren, e.mask);
          bad = 0;
          for (int j = 0; j < NL; j++) if (int'(wrptr[j]) != e.row) bad++;
          check_output("wrptr_lanes_bad", NL'(bad), '0);
          bad = 0;
          for (int j = 0; j < NL; j++)
            if (e.mask[j] && (8'(weight[j]) !== e.bytes[8*j +: 8])) bad++;
          check_output("weight_lanes_bad", NL'(bad), '0);
          check_output("done_with_write", NL'(done), NL'(e.done));
        end
        for (int j = 0; j < NL; j++) if (wren[j]) dut_img[wrptr[j]][j] = 8'(weight[j]);
      end
      if (done) done_cnt++;
      if (prev_done) check_output("busy_after_done", NL'(busy), '0);
      prev_done = done;
    end
  end

  task automatic apply_stimulus(input int rows_req, input bit rand_data, input int valid_pct,
                                input int abort_beat, input int glitch_beat);
    int              rows_eff, total, n, cyc, done0, stray, bad, row, lane;
    bit              pad;
    logic [8*BB-1:0] d;
    exp_t            e;
    rows_eff = (rows_req > DP) ? DP : rows_req;
    total    = rows_eff * BPR;
`ifdef FC_WLOAD_ZERO_PAD_EN
    pad = (rows_eff < DP);
`else
    pad = 1'b0;
`endif
    done0 = done_cnt;
    @(negedge clk);
    start_i = 1'b1; num_rows_i = (AW+1)'(rows_req);
    @(negedge clk);
    start_i = 1'b0;
    if (pad && rows_eff == 0) push_pad(0);
    n = 0; cyc = 0;
    while (n < total && cyc < 20000) begin
      if (n == abort_beat) begin
        s_if.valid = 1'b1;
        #2 rst = 1'b1;
        #1 check_reset_outputs();
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        repeat (10) begin
          @(negedge clk);
          if (wren != '0 || s_if.ready) stray++;
        end
        s_if.valid = 1'b0;
        check_output("writes_after_abort", NL'(stray), '0);
        check_output("queue_after_abort", NL'(exp_q.size()), '0);
        return;
      end
      s_if.valid = ($urandom_range(99) < valid_pct);
      start_i = (n == glitch_beat);
      if (n == glitch_beat) num_rows_i = 5;
      row  = n / BPR;
      lane = (n % BPR) * BB;
      for (int k = 0; k < BB; k++) d[8*k +: 8] = rand_data ? 8'($urandom) : 8'(row + 1);
      if (n == 5*BPR + 2) d = 32'h0403_0201;
      s_if.data = d;
      if (s_if.valid && s_if.ready) begin
        e.row = row; e.mask = '0; e.bytes = '0; e.done = (n == total-1) && !pad;
        for (int k = 0; k < BB; k++) begin
          e.mask[lane+k] = 1'b1;
          e.bytes[8*(lane+k) +: 8] = d[8*k +: 8];
          model_img[row][lane+k] = d[8*k +: 8];
        end
        exp_q.push_back(e);
        n++;
        if (n == total && pad) push_pad(rows_eff);
      end
      @(negedge clk);
      cyc++;
    end
    start_i = 1'b0;
    check_output("load_timeout", NL'(cyc < 20000), NL'(1));
    s_if.valid = 1'b1;
    stray = 0;
    repeat (8) begin
      if (s_if.ready) stray++;
      @(negedge clk);
    end
    s_if.valid = 1'b0;
    check_output("ready_after_last", NL'(stray), '0);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check_output("queue_drain", NL'(exp_q.size()), '0);
    check_output("done_pulses", NL'(done_cnt - done0), NL'(1));
    check_output("busy_idle", NL'(busy), '0);
    bad = 0;
    for (int r = 0; r < DP; r++)
      for (int j = 0; j < NL; j++)
        if (model_img[r][j] != dut_img[r][j]) bad++;
    check_output("image_bytes_bad", NL'(bad), '0);
  endtask

  initial begin : main
    s_if.valid = 1'b0;
    s_if.data  = '0;
    for (int r = 0; r < DP; r++)
      for (int j = 0; j < NL; j++) begin
        model_img[r][j] = 8'h00;
        dut_img[r][j]   = 8'h00;
      end
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    @(negedge clk);
    $display("[TB] 84 rows, byte = row+1, continuous valid");
    apply_stimulus(84, 1'b0, 100, -1, -1);
    $display("[TB] 84 rows, random bytes, 50%% valid");
    apply_stimulus(84, 1'b1, 50, -1, -1);
    $display("[TB] reset mid-load at row 40");
    apply_stimulus(128, 1'b1, 100, 40*BPR + 10, -1);
    $display("[TB] num_rows=200 clamped, start_i mid-load ignored");
    apply_stimulus(200, 1'b1, 80, -1, 300);
`ifdef FC_WLOAD_ZERO_PAD_EN
    $display("[TB] zero pad after 84 rows, then num_rows=0");
    apply_stimulus(84, 1'b0, 100, -1, -1);
    apply_stimulus(0, 1'b0, 100, -1, -1);
`else
    $display("[TB] num_rows=0 gives a lone done pulse");
    @(negedge clk);
    start_i = 1'b1; num_rows_i = '0;
    @(negedge clk);
    start_i = 1'b0;
    check_output("zero_rows_done", NL'(done), NL'(1));
    check_output("zero_rows_wren", wren, '0);
    check_output("zero_rows_busy", NL'(busy), '0);
    @(negedge clk);
    check_output("zero_rows_done_clear", NL'(done), '0);
`endif
    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
